// File: rtl/pll_reset_seq.sv
// pll_reset_seq: sequences PLL reset, qualifies lock with stability/timeout/retry,
// and releases the system reset from the reference-clock domain.
module pll_reset_seq #(
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_STABLE_CYCLES  = 64,
    parameter int LOCK_TIMEOUT_CYCLES = 4096,
    parameter int SYS_HOLD_CYCLES     = 32,
    parameter int CNT_W               = 8
) (
    input  logic             clkin,
    input  logic             rst_n,
    input  logic             locked_async,
    input  logic             soft_req,
    output logic             pll_rst,
    output logic             sys_rst_n,
    output logic             ready,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] retry_cnt,
    output logic [CNT_W-1:0] loss_cnt
);
    localparam int MAX_AB = PLL_RST_CYCLES > SYS_HOLD_CYCLES ? PLL_RST_CYCLES : SYS_HOLD_CYCLES;
    localparam int MAXC   = MAX_AB > LOCK_TIMEOUT_CYCLES ? MAX_AB : LOCK_TIMEOUT_CYCLES;
    localparam int CW     = $clog2(MAXC) + 1;
    localparam int SW     = $clog2(LOCK_STABLE_CYCLES) + 1;
    localparam logic [CW-1:0] PR_LAST = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] HD_LAST = CW'(SYS_HOLD_CYCLES - 1);
    localparam logic [SW-1:0] ST_LAST = SW'(LOCK_STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_PLL_RST = 2'b00,
        S_WAIT    = 2'b01,
        S_HOLD    = 2'b10,
        S_RUN     = 2'b11
    } st_t;

    st_t           cur, nxt;
    logic          sync1, lock_s;
    logic [CW-1:0] cnt;
    logic [SW-1:0] stab;
    logic          accept, timeout, lost, drop;
    logic          pll_rst_d, run_d;

    assign state = cur;

    // stab already holds the previous consecutive-high cycles, so this cycle is the last one needed
    always_comb begin
        accept  = cur == S_WAIT && lock_s && stab == ST_LAST;
        timeout = cur == S_WAIT && !accept && cnt == TO_LAST;
        lost    = cur == S_RUN && !lock_s;
        drop    = !lock_s || soft_req;
    end

    always_comb begin
        nxt = cur;
        case (cur)
            S_PLL_RST: nxt = cnt == PR_LAST ? S_WAIT : S_PLL_RST;
            S_WAIT:    nxt = accept ? S_HOLD : timeout ? S_PLL_RST : S_WAIT;
            S_HOLD:    nxt = drop ? S_PLL_RST : cnt == HD_LAST ? S_RUN : S_HOLD;
            default:   nxt = drop ? S_PLL_RST : S_RUN;
        endcase
    end

    always_comb begin
        pll_rst_d = nxt == S_PLL_RST;
        run_d     = nxt == S_RUN;
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= 1'b0;
            lock_s    <= 1'b0;
            cur       <= S_PLL_RST;
            cnt       <= '0;
            stab      <= '0;
            retry_cnt <= '0;
            loss_cnt  <= '0;
            pll_rst   <= 1'b1;
            sys_rst_n <= 1'b0;
            ready     <= 1'b0;
        end else begin
            sync1     <= locked_async;
            lock_s    <= sync1;
            cur       <= nxt;
            cnt       <= (nxt != cur || cur == S_RUN) ? '0 : cnt + 1'b1;
            stab      <= (cur == S_WAIT && nxt == S_WAIT && lock_s) ? stab + 1'b1 : '0;
            if (timeout && ~&retry_cnt) retry_cnt <= retry_cnt + 1'b1;
            if (lost && ~&loss_cnt) loss_cnt <= loss_cnt + 1'b1;
            pll_rst   <= pll_rst_d;
            sys_rst_n <= run_d;
            ready     <= run_d;
        end
    end
endmodule

// File: tb/tb_pll_reset_seq.sv
// tb_pll_reset_seq: random and directed stimulus against a phase/elapsed-time
// reference model, with a queue-based scoreboard checked once per clock.
module tb_pll_reset_seq;
    localparam int PR = 4, ST = 8, TO = 24, HD = 6, CW = 4;
    localparam int SAT = 2 ** CW - 1;

    typedef struct packed {
        logic [1:0]    st;
        logic          pll;
        logic          sys;
        logic          rdy;
        logic [CW-1:0] rt;
        logic [CW-1:0] ls;
    } obs_t;

    logic          clkin = 0, rst_n = 0, locked_async = 0, soft_req = 0;
    logic          pll_rst, sys_rst_n, ready;
    logic [1:0]    state;
    logic [CW-1:0] retry_cnt, loss_cnt;

    obs_t exp_q[$];
    int   checks = 0, errors = 0;
    bit   go = 0;
    int   ph, t, run, m_rt, m_ls;
    bit   dl[$];

    pll_reset_seq #(
        .PLL_RST_CYCLES(PR), .LOCK_STABLE_CYCLES(ST), .LOCK_TIMEOUT_CYCLES(TO),
        .SYS_HOLD_CYCLES(HD), .CNT_W(CW)
    ) dut (
        .clkin(clkin), .rst_n(rst_n), .locked_async(locked_async), .soft_req(soft_req),
        .pll_rst(pll_rst), .sys_rst_n(sys_rst_n), .ready(ready), .state(state),
        .retry_cnt(retry_cnt), .loss_cnt(loss_cnt)
    );

    always #5 clkin = ~clkin;

    function automatic obs_t dut_obs();
        obs_t o;
        o.st = state; o.pll = pll_rst; o.sys = sys_rst_n; o.rdy = ready;
        o.rt = retry_cnt; o.ls = loss_cnt;
        return o;
    endfunction

    function automatic obs_t model_obs();
        obs_t o;
        o.st = 2'(ph); o.pll = ph == 0; o.sys = ph == 3; o.rdy = ph == 3;
        o.rt = CW'(m_rt); o.ls = CW'(m_ls);
        return o;
    endfunction

    task automatic model_reset();
        ph = 0; t = 0; run = 0; m_rt = 0; m_ls = 0;
        dl = '{0, 0};
    endtask

    task automatic enter(input int p);
        ph = p; t = 0; run = 0;
    endtask

    // Phases: 0 PLL reset, 1 wait for lock, 2 hold, 3 run; lock seen two edges late.
    task automatic model_step(input bit lk, input bit sr);
        bit ls;
        ls = dl.pop_front();
        dl.push_back(lk);
        case (ph)
            0: if (t + 1 == PR) enter(1); else t++;
            1: begin
                run = ls ? run + 1 : 0;
                if (run == ST) enter(2);
                else if (t + 1 == TO) begin
                    if (m_rt < SAT) m_rt++;
                    enter(0);
                end else t++;
            end
            2: if (!ls || sr) enter(0); else if (t + 1 == HD) enter(3); else t++;
            default: if (!ls) begin
                if (m_ls < SAT) m_ls++;
                enter(0);
            end else if (sr) enter(0);
        endcase
    endtask

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", n, a, e, $time);
        end
    endtask

    task automatic cyc(input bit lk, input bit sr);
        @(negedge clkin);
        rst_n = 1; locked_async = lk; soft_req = sr;
        model_step(lk, sr);
        exp_q.push_back(model_obs());
    endtask

    task automatic after_edge();
        @(posedge clkin);
        #3;
    endtask

    task automatic do_reset();
        obs_t r;
        @(negedge clkin);
        #2 rst_n = 0;
        #1;
        model_reset();
        r = model_obs();
        chk("async_rst", dut_obs(), r);
        exp_q.push_back(r);
    endtask

    initial begin : monitor
        obs_t e, a;
        forever begin
            @(posedge clkin);
            #2;
            if (go) begin
                checks++;
                a = dut_obs();
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard underflow at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    if (a !== e) begin
                        errors++;
                        $display("FAIL cycle %0t got st=%b pll=%b sys=%b rdy=%b rt=%0d ls=%0d want st=%b pll=%b sys=%b rdy=%b rt=%0d ls=%0d",
                                 $time, a.st, a.pll, a.sys, a.rdy, a.rt, a.ls, e.st, e.pll, e.sys, e.rdy, e.rt, e.ls);
                    end
                end
            end
        end
    end

    initial begin : stim
        int n, guard;
        model_reset();
        repeat (2) @(posedge clkin);
        #3;
        chk("reset_state", dut_obs(), model_obs());
        go = 1;
        // clean power-up: RUN entered on edge PR+ST+HD
        for (int i = 1; i <= 30; i++) begin
            cyc(1, 0);
            if (i == PR + ST + HD - 1 || i == PR + ST + HD) begin
                after_edge();
                chk("run_entry", sys_rst_n, i == PR + ST + HD);
            end
        end
        // lock loss in RUN: system reset 3 edges after the drop
        for (int j = 1; j <= 3; j++) begin
            cyc(0, 0);
            after_edge();
            chk("loss_latency", sys_rst_n, j < 3);
        end
        chk("loss_count", loss_cnt, 1);
        repeat (40) cyc(1, 0);
        chk("relock_run", state, 2'b11);
        // soft request in RUN, then in WAIT_LOCK
        cyc(1, 1);
        after_edge();
        chk("soft_run_state", state, 2'b00);
        chk("soft_run_loss", loss_cnt, 1);
        repeat (PR + 2) cyc(1, 0);
        cyc(1, 1);
        after_edge();
        chk("soft_wait_ignored", state, 2'b01);
        repeat (30) cyc(1, 0);
        // lock glitch while waiting: stability count restarts
        do_reset();
        for (int i = 1; i <= 30; i++) begin
            cyc(i != 10, 0);
            if (i == 19 || i == 20) begin
                after_edge();
                chk("glitch_hold", state, i == 20 ? 2'b10 : 2'b01);
            end
        end
        // no lock: repeated timeouts saturate retry_cnt
        repeat (20 * (PR + TO)) cyc(0, 0);
        chk("retry_sat", retry_cnt, SAT);
        // randomized lock segments and soft requests
        n = 0;
        while (n < 3000) begin
            int len;
            bit lv;
            lv  = $urandom_range(0, 3) != 0;
            len = lv ? $urandom_range(1, 60) : $urandom_range(1, 4);
            for (int k = 0; k < len; k++) cyc(lv, $urandom_range(0, 19) == 0);
            n += len;
        end
        // asynchronous reset while in HOLD
        guard = 0;
        while (ph != 2 && guard < 200) begin
            cyc(1, 0);
            guard++;
        end
        chk("hold_reached", ph, 2);
        cyc(1, 0);
        do_reset();
        repeat (30) cyc(1, 0);
        after_edge();
        go = 0;
        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
